// File: rtl/hadamard_out_serializer_if.sv
`default_nettype none
// ============================================================================
// Module  : hadamard_out_serializer_if
// Brief   : Frame-in / beat-out handshake bundle for the Hadamard serializer.
// Revision: 1.0
// ============================================================================
interface hadamard_out_serializer_if #(
  parameter int N = 16,
  parameter int W = 10
);
  logic                in_valid;
  logic                in_ready;
  logic [N*W-1:0]      y_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic [3:0]          out_idx;
  logic                out_last;
  logic                peak_valid;
  logic [W-1:0]        peak_abs;
  logic [3:0]          peak_idx;

  modport slave (
    input  in_valid, y_in, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last,
           peak_valid, peak_abs, peak_idx
  );

  modport master (
    output in_valid, y_in, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last,
           peak_valid, peak_abs, peak_idx
  );
endinterface
`default_nettype wire

// File: rtl/hadamard_out_serializer.sv
`default_nettype none
// ============================================================================
// Module  : hadamard_out_serializer
// Brief   : Buffers a 16-coefficient frame and streams it one beat per
//           handshake, reporting the frame's peak magnitude at the end.
// Revision: 1.0
// ============================================================================
module hadamard_out_serializer #(
  parameter int N = 16,
  parameter int W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  hadamard_out_serializer_if.slave bus
);
  localparam logic [3:0]   c_last    = 4'(N - 1);
  localparam logic [W-1:0] c_mag_max = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_idx, w_idx_nxt;
  logic signed [W-1:0] r_buf [N];
  logic signed [W-1:0] w_y   [N];

  logic                w_out_valid, w_in_ready, w_accept;
  logic                w_xfer, w_xfer_last, w_beat_wins;
  logic signed [W-1:0] w_cur, w_neg;
  logic [W-1:0]        w_mag;

  logic [W-1:0]        r_run_abs, r_peak_abs;
  logic [3:0]          r_run_idx, r_peak_idx;
  logic                r_peak_valid;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign w_y[k] = bus.y_in[k*W +: W];
  end

  // rst gates every output so the block looks idle during the reset cycle itself
  assign w_out_valid = (r_state == STREAM) && !rst;
  assign w_xfer      = w_out_valid && bus.out_ready;
  assign w_xfer_last = w_xfer && (r_idx == c_last);
  assign w_in_ready  = !rst && ((r_state == IDLE) || w_xfer_last);
  assign w_accept    = bus.in_valid && w_in_ready;

  assign w_cur = r_buf[r_idx];
  assign w_neg = -w_cur;

  // Negating the most negative code wraps back to itself; clamp it instead
  always_comb begin
    w_mag = w_cur;
    if (w_cur[W-1]) begin
      w_mag = w_neg[W-1] ? c_mag_max : w_neg;
    end
  end

  assign w_beat_wins = (r_idx == 4'd0) || (w_mag > r_run_abs);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = STREAM;
          w_idx_nxt   = 4'd0;
        end
      end
      STREAM: begin
        if (w_xfer_last) begin
          w_idx_nxt   = 4'd0;
          w_state_nxt = w_accept ? STREAM : IDLE;
        end else if (w_xfer) begin
          w_idx_nxt = r_idx + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < N; k++) begin
        r_buf[k] <= w_y[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_abs    <= '0;
      r_run_idx    <= 4'd0;
      r_peak_abs   <= '0;
      r_peak_idx   <= 4'd0;
      r_peak_valid <= 1'b0;
    end else begin
      r_peak_valid <= w_xfer_last;
      if (w_xfer && w_beat_wins) begin
        r_run_abs <= w_mag;
        r_run_idx <= r_idx;
      end
      if (w_xfer_last) begin
        r_peak_abs <= w_beat_wins ? w_mag : r_run_abs;
        r_peak_idx <= w_beat_wins ? r_idx : r_run_idx;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? w_cur : '0;
  assign bus.out_idx    = w_out_valid ? r_idx : 4'd0;
  assign bus.out_last   = w_out_valid && (r_idx == c_last);
  assign bus.peak_valid = r_peak_valid && !rst;
  assign bus.peak_abs   = rst ? '0 : r_peak_abs;
  assign bus.peak_idx   = rst ? 4'd0 : r_peak_idx;

endmodule
`default_nettype wire

// File: tb/tb_hadamard_out_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_hadamard_out_serializer
// Brief   : Directed table, corner sequences and random traffic against a
//           frame-queue model of the serializer.
// Revision: 1.0
// ============================================================================
module tb_hadamard_out_serializer;
  localparam int N = 16;
  localparam int W = 10;
  localparam int c_mag_max = (1 << (W - 1)) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hadamard_out_serializer_if #(.N(N), .W(W)) bus ();
  hadamard_out_serializer #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] put(input logic [N*W-1:0] f, input int k, input int v);
    logic [W-1:0] c;
    c = W'(v);
    f[k*W +: W] = c;
    return f;
  endfunction

  function automatic void frame_peak(input logic [N*W-1:0] f, output int pabs, output int pidx);
    logic signed [W-1:0] s;
    int v, m;
    pabs = -1;
    pidx = 0;
    for (int k = 0; k < N; k++) begin
      s = f[k*W +: W];
      v = s;
      m = (v < 0) ? -v : v;
      if (m > c_mag_max) m = c_mag_max;
      if (m > pabs) begin
        pabs = m;
        pidx = k;
      end
    end
  endfunction

  // ---------------- reference model: queue of pending beats -------------
  typedef struct { int data; int idx; int pabs; int pidx; } beat_t;
  beat_t q[$];
  bit exp_pulse = 1'b0;
  int exp_pabs = 0, exp_pidx = 0, m_pabs = 0, m_pidx = 0;

  always @(negedge clk) begin : monitor
    beat_t b;
    logic signed [W-1:0] s;
    int pending, e_ready, fa, fi;
    if (rst) begin
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst in_ready", bus.in_ready, 0);
      chk("rst out_data", bus.out_data, 0);
      chk("rst out_last", bus.out_last, 0);
      chk("rst peak_valid", bus.peak_valid, 0);
      chk("rst peak_abs", bus.peak_abs, 0);
      chk("rst peak_idx", bus.peak_idx, 0);
      q.delete();
      exp_pulse = 1'b0;
      m_pabs = 0;
      m_pidx = 0;
    end else begin
      pending = q.size();
      e_ready = (pending == 0 || (bus.out_ready && pending == 1)) ? 1 : 0;
      chk("in_ready", bus.in_ready, e_ready);
      chk("out_valid", bus.out_valid, (pending > 0) ? 1 : 0);
      if (pending > 0) begin
        chk("out_data", bus.out_data, q[0].data);
        chk("out_idx", bus.out_idx, q[0].idx);
        chk("out_last", bus.out_last, (q[0].idx == 15) ? 1 : 0);
      end else begin
        chk("idle out_data", bus.out_data, 0);
        chk("idle out_idx", bus.out_idx, 0);
        chk("idle out_last", bus.out_last, 0);
      end
      chk("peak_valid", bus.peak_valid, exp_pulse ? 1 : 0);
      if (exp_pulse) begin
        m_pabs = exp_pabs;
        m_pidx = exp_pidx;
      end
      chk("peak_abs", bus.peak_abs, m_pabs);
      chk("peak_idx", bus.peak_idx, m_pidx);
      exp_pulse = 1'b0;
      if (pending > 0 && bus.out_ready) begin
        b = q.pop_front();
        if (b.idx == 15) begin
          exp_pulse = 1'b1;
          exp_pabs = b.pabs;
          exp_pidx = b.pidx;
        end
      end
      if (bus.in_valid && e_ready == 1) begin
        frame_peak(bus.y_in, fa, fi);
        for (int k = 0; k < N; k++) begin
          s = bus.y_in[k*W +: W];
          b.data = s;
          b.idx = k;
          b.pabs = fa;
          b.pidx = fi;
          q.push_back(b);
        end
      end
    end
  end

  // ---------------- stimulus helpers (drive at posedge + 1) -------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [N*W-1:0] y, input int stall_idx,
                           input int stall_len, output int cycles);
    int stalls, guard;
    bit done;
    bus.in_valid = 1'b1;
    bus.y_in = y;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("first beat latency", bus.out_valid, 1);
    cycles = 0;
    stalls = 0;
    guard = 0;
    done = 1'b0;
    while (!done && guard < 100) begin
      if (bus.out_valid) begin
        cycles++;
        if (bus.out_idx == 4'(stall_idx) && stalls < stall_len) begin
          bus.out_ready = 1'b0;
          stalls++;
        end else begin
          bus.out_ready = 1'b1;
        end
        if (bus.out_ready && bus.out_idx == 4'd15) done = 1'b1;
      end
      guard++;
      tick();
    end
    bus.out_ready = 1'b1;
    if (!done) chk("frame timeout", 0, 1);
  endtask

  function automatic logic [N*W-1:0] rand_frame();
    logic [N*W-1:0] f;
    int sel;
    f = '0;
    for (int k = 0; k < N; k++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0) f = put(f, k, -512);
      else if (sel == 1) f = put(f, k, 511);
      else f = put(f, k, int'($urandom));
    end
    return f;
  endfunction

  typedef struct {
    logic [N*W-1:0] y;
    int stall_idx;
    int stall_len;
    int exp_cycles;
    int exp_pabs;
    int exp_pidx;
  } vec_t;

  vec_t vecs[6];

  initial begin : stim
    logic [N*W-1:0] f;
    int cyc, vcnt, first_v, last_v, npulse, p1, p2, guard;
    bit pulsed;

    f = '0;
    for (int k = 0; k < N; k++) f = put(f, k, k - 8);
    vecs[0] = '{f, -1, 0, 16, 8, 0};
    vecs[2] = '{f, 6, 5, 21, 8, 0};
    f = '0;
    f = put(f, 3, -512);
    f = put(f, 9, 511);
    vecs[1] = '{f, -1, 0, 16, 511, 3};
    vecs[3] = '{'0, -1, 0, 16, 0, 0};
    f = '0;
    for (int k = 0; k < N; k++) f = put(f, k, (k == 15) ? -3 : 2);
    vecs[4] = '{f, -1, 0, 16, 3, 15};
    f = '0;
    f = put(f, 7, 100);
    f = put(f, 12, -100);
    vecs[5] = '{f, 15, 3, 19, 100, 7};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.y_in = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("in_ready after reset", bus.in_ready, 1);
    chk("out_valid after reset", bus.out_valid, 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].y, vecs[i].stall_idx, vecs[i].stall_len, cyc);
      chk($sformatf("vec%0d cycles", i), cyc, vecs[i].exp_cycles);
      chk($sformatf("vec%0d peak_valid", i), bus.peak_valid, 1);
      chk($sformatf("vec%0d peak_abs", i), bus.peak_abs, vecs[i].exp_pabs);
      chk($sformatf("vec%0d peak_idx", i), bus.peak_idx, vecs[i].exp_pidx);
    end

    // Back-to-back: second frame waits with in_valid held high
    bus.in_valid = 1'b1;
    bus.y_in = vecs[0].y;
    tick();
    bus.y_in = vecs[1].y;
    vcnt = 0; first_v = -1; last_v = -1; npulse = 0; p1 = -1; p2 = -1;
    for (int i = 0; i <= 40; i++) begin
      if (i == 16) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        vcnt++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (bus.peak_valid) begin
        npulse++;
        if (p1 < 0) p1 = i; else p2 = i;
      end
      tick();
    end
    chk("b2b beat cycles", vcnt, 32);
    chk("b2b first beat", first_v, 0);
    chk("b2b last beat", last_v, 31);
    chk("b2b pulse count", npulse, 2);
    chk("b2b pulse spacing", p2 - p1, 16);

    // Ignored frame offered mid-stream
    bus.in_valid = 1'b1;
    bus.y_in = vecs[4].y;
    tick();
    bus.in_valid = 1'b0;
    vcnt = 0;
    pulsed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) vcnt++;
      if (bus.out_valid && bus.out_idx == 4'd4 && !pulsed) begin
        bus.in_valid = 1'b1;
        bus.y_in = vecs[1].y;
        pulsed = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end
    chk("ignored frame beats", vcnt, 16);

    // Reset while idx 9 is on the output
    bus.in_valid = 1'b1;
    bus.y_in = vecs[0].y;
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (!(bus.out_valid && bus.out_idx == 4'd9) && guard < 40) begin
      guard++;
      tick();
    end
    if (guard >= 40) chk("reach idx 9 timeout", 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("post-rst out_valid", bus.out_valid, 0);
    chk("post-rst in_ready", bus.in_ready, 1);
    npulse = 0;
    vcnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.peak_valid) npulse++;
      if (bus.out_valid) vcnt++;
      tick();
    end
    chk("abandoned frame pulses", npulse, 0);
    chk("abandoned frame beats", vcnt, 0);
    run_frame(vecs[5].y, -1, 0, cyc);
    chk("post-rst frame cycles", cyc, 16);
    chk("post-rst peak_abs", bus.peak_abs, 100);
    chk("post-rst peak_idx", bus.peak_idx, 7);

    // Random traffic, checked entirely by the monitor
    for (int i = 0; i < 1500; i++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.in_valid = ($urandom_range(0, 1) == 0);
      bus.y_in = rand_frame();
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (40) tick();
    chk("drain empty", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
